// File: rtl/rggen_bit_field_pkg.sv
// Shared definitions for the rggen bit-field family: set-direction
// encodings and bus access decode helpers.
package rggen_bit_field_pkg;

    localparam int RGGEN_SET_BY_HW = 0;
    localparam int RGGEN_SET_BY_SW = 1;

    function automatic logic is_write_access(
        input logic command_valid,
        input logic select,
        input logic write
    );
        return command_valid & select & write;
    endfunction

    function automatic logic is_read_access(
        input logic command_valid,
        input logic select,
        input logic write
    );
        return command_valid & select & ~write;
    endfunction

endpackage

// File: rtl/rggen_bit_field_edge_detector.sv
// Per-bit rising-edge detector. History resets to all-ones so an input
// already high when reset is released does not register as an edge.
module rggen_bit_field_edge_detector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] hist;

    // Capture the previous input value every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '1;
        end else begin
            hist <= i_in;
        end
    end

    assign o_rise = i_in & ~hist;

endmodule

// File: rtl/rggen_bit_field_w01sc_event.sv
// Set/clear status bit field with write-1 or write-0 software action,
// selectable set direction, optional edge-detected hardware events,
// read-to-clear, sticky overflow capture and a registered masked IRQ.
module rggen_bit_field_w01sc_event
    import rggen_bit_field_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE   = '0,
    parameter int               SET_MODE        = 0,
    parameter int               SET_CLEAR_VALUE = 1,
    parameter int               HW_EDGE         = 0,
    parameter int               READ_CLEAR      = 0,
    parameter int               OVERFLOW_EN     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_hw_event,
    input  logic             i_command_valid,
    input  logic             i_select,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [WIDTH-1:0] i_write_mask,
    input  logic [WIDTH-1:0] i_irq_enable,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_overflow,
    output logic             o_irq
);

    logic [WIDTH-1:0] hw;
    logic [WIDTH-1:0] sw_ctl;
    logic [WIDTH-1:0] rd_clr;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] value_q;
    logic             irq_q;

    generate
        if (HW_EDGE != 0) begin : g_edge
            rggen_bit_field_edge_detector #(
                .WIDTH (WIDTH)
            ) u_edge (
                .clk    (clk),
                .rst    (rst),
                .i_in   (i_hw_event),
                .o_rise (hw)
            );
        end else begin : g_level
            assign hw = i_hw_event;
        end
    endgenerate

    // Software action bits from a masked write (polarity selectable).
    always_comb begin
        sw_ctl = '0;
        if (is_write_access(i_command_valid, i_select, i_write)) begin
            sw_ctl = i_write_mask &
                     ((SET_CLEAR_VALUE != 0) ? i_write_data : ~i_write_data);
        end
    end

    // Read-to-clear applies to every bit, only in hardware-set mode.
    always_comb begin
        rd_clr = '0;
        if ((READ_CLEAR != 0) && (SET_MODE == RGGEN_SET_BY_HW) &&
            is_read_access(i_command_valid, i_select, i_write)) begin
            rd_clr = '1;
        end
    end

    // Route hardware and software requests to set/clear by direction.
    always_comb begin
        if (SET_MODE == RGGEN_SET_BY_HW) begin
            set_bits = hw;
            clr_bits = sw_ctl | rd_clr;
        end else begin
            set_bits = sw_ctl;
            clr_bits = hw;
        end
    end

    // Field register: set wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= INITIAL_VALUE;
        end else begin
            value_q <= set_bits | (value_q & ~clr_bits);
        end
    end

    generate
        if ((SET_MODE == RGGEN_SET_BY_HW) && (OVERFLOW_EN != 0)) begin : g_ovf
            logic [WIDTH-1:0] ovf_q;

            // Sticky overflow: hardware set onto an already-set, uncleared bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= '0;
                end else begin
                    ovf_q <= (hw & value_q & ~clr_bits) | (ovf_q & ~clr_bits);
                end
            end

            assign o_overflow = ovf_q;
        end else begin : g_no_ovf
            assign o_overflow = '0;
        end
    endgenerate

    // Registered interrupt from the enabled field bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(value_q & i_irq_enable);
        end
    end

    assign o_value = value_q;
    assign o_irq   = irq_q;

endmodule

// File: tb/tb_rggen_bit_field_w01sc_event.sv
// Self-checking bench: five field configurations share one stimulus
// stream; a per-bit behavioural model predicts every output.
module tb_rggen_bit_field_w01sc_event;

    localparam int N = 5;
    // Instance k configuration bits: 0=A base, 1=B write-0, 2=C edge,
    // 3=D read-clear, 4=E software-set.
    localparam logic [N-1:0] C_MODE = 5'b10000;
    localparam logic [N-1:0] C_SCV  = 5'b11101;
    localparam logic [N-1:0] C_EDGE = 5'b00100;
    localparam logic [N-1:0] C_RC   = 5'b01000;
    localparam logic [N-1:0] C_OVF  = 5'b11111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hw_event = '0;
    logic       cv = 1'b0, sel = 1'b0, wr = 1'b0;
    logic [3:0] wdata = '0, wmask = '0, irq_en = '0;
    logic [3:0] value [N];
    logic [3:0] ovf   [N];
    logic       irq   [N];

    logic [3:0] m_val [N];
    logic [3:0] m_ovf [N];
    logic [3:0] m_hist[N];
    logic       m_irq [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rggen_bit_field_w01sc_event #(.WIDTH(4), .INITIAL_VALUE(4'b0000), .SET_MODE(0),
        .SET_CLEAR_VALUE(1), .HW_EDGE(0), .READ_CLEAR(0), .OVERFLOW_EN(1)) u_a (
        .clk(clk), .rst(rst), .i_hw_event(hw_event), .i_command_valid(cv), .i_select(sel),
        .i_write(wr), .i_write_data(wdata), .i_write_mask(wmask), .i_irq_enable(irq_en),
        .o_value(value[0]), .o_overflow(ovf[0]), .o_irq(irq[0]));
    rggen_bit_field_w01sc_event #(.WIDTH(4), .INITIAL_VALUE(4'b0000), .SET_MODE(0),
        .SET_CLEAR_VALUE(0), .HW_EDGE(0), .READ_CLEAR(0), .OVERFLOW_EN(1)) u_b (
        .clk(clk), .rst(rst), .i_hw_event(hw_event), .i_command_valid(cv), .i_select(sel),
        .i_write(wr), .i_write_data(wdata), .i_write_mask(wmask), .i_irq_enable(irq_en),
        .o_value(value[1]), .o_overflow(ovf[1]), .o_irq(irq[1]));
    rggen_bit_field_w01sc_event #(.WIDTH(4), .INITIAL_VALUE(4'b0000), .SET_MODE(0),
        .SET_CLEAR_VALUE(1), .HW_EDGE(1), .READ_CLEAR(0), .OVERFLOW_EN(1)) u_c (
        .clk(clk), .rst(rst), .i_hw_event(hw_event), .i_command_valid(cv), .i_select(sel),
        .i_write(wr), .i_write_data(wdata), .i_write_mask(wmask), .i_irq_enable(irq_en),
        .o_value(value[2]), .o_overflow(ovf[2]), .o_irq(irq[2]));
    rggen_bit_field_w01sc_event #(.WIDTH(4), .INITIAL_VALUE(4'b0000), .SET_MODE(0),
        .SET_CLEAR_VALUE(1), .HW_EDGE(0), .READ_CLEAR(1), .OVERFLOW_EN(1)) u_d (
        .clk(clk), .rst(rst), .i_hw_event(hw_event), .i_command_valid(cv), .i_select(sel),
        .i_write(wr), .i_write_data(wdata), .i_write_mask(wmask), .i_irq_enable(irq_en),
        .o_value(value[3]), .o_overflow(ovf[3]), .o_irq(irq[3]));
    rggen_bit_field_w01sc_event #(.WIDTH(4), .INITIAL_VALUE(4'b1000), .SET_MODE(1),
        .SET_CLEAR_VALUE(1), .HW_EDGE(0), .READ_CLEAR(1), .OVERFLOW_EN(1)) u_e (
        .clk(clk), .rst(rst), .i_hw_event(hw_event), .i_command_valid(cv), .i_select(sel),
        .i_write(wr), .i_write_data(wdata), .i_write_mask(wmask), .i_irq_enable(irq_en),
        .o_value(value[4]), .o_overflow(ovf[4]), .o_irq(irq[4]));

    function automatic logic [3:0] init_of(input int k);
        return (k == 4) ? 4'b1000 : 4'b0000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_val[k]  = init_of(k);
            m_ovf[k]  = '0;
            m_irq[k]  = 1'b0;
            m_hist[k] = '1;
        end
    endtask

    // One clock edge of the reference, evaluated bit by bit from the rules.
    task automatic model_update();
        logic is_wr, is_rd, ev, sw, s, c, old;
        if (rst) begin
            model_reset();
            return;
        end
        is_wr = cv && sel && wr;
        is_rd = cv && sel && !wr;
        for (int k = 0; k < N; k++) begin
            m_irq[k] = (m_val[k] & irq_en) != 4'b0000;
            for (int b = 0; b < 4; b++) begin
                ev = hw_event[b] && (!C_EDGE[k] || !m_hist[k][b]);
                sw = is_wr && wmask[b] && (wdata[b] == C_SCV[k]);
                if (!C_MODE[k]) begin
                    s = ev;
                    c = sw || (is_rd && C_RC[k]);
                end else begin
                    s = sw;
                    c = ev;
                end
                old = m_val[k][b];
                if (s)      m_val[k][b] = 1'b1;
                else if (c) m_val[k][b] = 1'b0;
                if (!C_MODE[k] && C_OVF[k]) begin
                    if (c)             m_ovf[k][b] = 1'b0;
                    else if (ev && old) m_ovf[k][b] = 1'b1;
                end
            end
            m_hist[k] = hw_event;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic bus_idle();
        cv = 1'b0; sel = 1'b0; wr = 1'b0; wdata = '0; wmask = '0;
    endtask

    task automatic bus_write(input logic [3:0] d, input logic [3:0] m);
        cv = 1'b1; sel = 1'b1; wr = 1'b1; wdata = d; wmask = m;
    endtask

    task automatic bus_read();
        cv = 1'b1; sel = 1'b1; wr = 1'b0; wdata = '0; wmask = '0;
    endtask

    task automatic do_reset(input logic [3:0] hw_hold);
        rst = 1'b1; bus_idle(); hw_event = hw_hold; irq_en = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4'b0100);
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (value[k] !== init_of(k) || ovf[k] !== 4'b0000 || irq[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d] value=%b ovf=%b irq=%b required %b/0000/0",
                         k, value[k], ovf[k], irq[k], init_of(k));
            end
        end
        tick();
        n_checks++;
        if (value[2] !== 4'b0000) begin
            n_fail++; $display("FAIL edge_at_release value=%b required 0000", value[2]);
        end
        n_checks++;
        if (value[0] !== 4'b0100) begin
            n_fail++; $display("FAIL level_at_release value=%b required 0100", value[0]);
        end
    endtask

    task automatic test_level_set();
        do_reset(4'b0000);
        irq_en = 4'b0001; hw_event = 4'b0101;
        tick();
        hw_event = '0;
        n_checks++;
        if (value[0] !== 4'b0101 || irq[0] !== 1'b0) begin
            n_fail++; $display("FAIL level_set value=%b irq=%b required 0101/0", value[0], irq[0]);
        end
        tick();
        n_checks++;
        if (irq[0] !== 1'b1) begin
            n_fail++; $display("FAIL irq_lag irq=%b required 1", irq[0]);
        end
    endtask

    task automatic test_write_clear();
        bus_write(4'b0001, 4'b1111);
        tick();
        n_checks++;
        if (value[0] !== 4'b0100 || value[1] !== 4'b0001) begin
            n_fail++; $display("FAIL w1c A=%b B=%b required 0100/0001", value[0], value[1]);
        end
        bus_write(4'b1110, 4'b1111);
        tick();
        n_checks++;
        if (value[0] !== 4'b0000 || value[1] !== 4'b0000) begin
            n_fail++; $display("FAIL w0c A=%b B=%b required 0000/0000", value[0], value[1]);
        end
        bus_idle(); hw_event = 4'b0011;
        tick();
        hw_event = '0; bus_write(4'b1111, 4'b0000);
        tick();
        bus_write(4'b0000, 4'b0000);
        tick();
        bus_idle();
        n_checks++;
        if (value[0] !== 4'b0011 || value[1] !== 4'b0011) begin
            n_fail++; $display("FAIL mask_zero A=%b B=%b required 0011/0011", value[0], value[1]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(4'b0000);
        hw_event = 4'b0001;
        tick();
        bus_write(4'b0001, 4'b0001);
        tick();
        n_checks++;
        if (value[0] !== 4'b0001 || ovf[0] !== 4'b0000) begin
            n_fail++; $display("FAIL set_wins value=%b ovf=%b required 0001/0000", value[0], ovf[0]);
        end
        bus_idle();
        tick();
        n_checks++;
        if (ovf[0] !== 4'b0001) begin
            n_fail++; $display("FAIL ovf_capture ovf=%b required 0001", ovf[0]);
        end
        hw_event = '0; bus_write(4'b0001, 4'b0001);
        tick();
        bus_idle();
        n_checks++;
        if (value[0] !== 4'b0000 || ovf[0] !== 4'b0000) begin
            n_fail++; $display("FAIL ovf_clear value=%b ovf=%b required 0000/0000", value[0], ovf[0]);
        end
    endtask

    task automatic test_edge();
        do_reset(4'b0100);
        tick();
        hw_event = '0;
        tick();
        hw_event = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (value[2] !== 4'b0100) begin
            n_fail++; $display("FAIL edge_once value=%b required 0100", value[2]);
        end
        bus_write(4'b0100, 4'b0100);
        tick();
        bus_idle();
        tick();
        n_checks++;
        if (value[2] !== 4'b0000) begin
            n_fail++; $display("FAIL edge_held_clear value=%b required 0000", value[2]);
        end
        hw_event = '0;
    endtask

    task automatic test_read_clear();
        do_reset(4'b0000);
        hw_event = 4'b1010;
        tick();
        hw_event = '0; bus_read();
        n_checks++;
        if (value[3] !== 4'b1010) begin
            n_fail++; $display("FAIL read_data value=%b required 1010", value[3]);
        end
        tick();
        bus_idle();
        n_checks++;
        if (value[3] !== 4'b0000 || value[0] !== 4'b1010) begin
            n_fail++; $display("FAIL read_clear D=%b A=%b required 0000/1010", value[3], value[0]);
        end
        hw_event = 4'b1010;
        tick();
        hw_event = 4'b0010; bus_read();
        tick();
        hw_event = '0; bus_idle();
        n_checks++;
        if (value[3] !== 4'b0010) begin
            n_fail++; $display("FAIL read_vs_hw value=%b required 0010", value[3]);
        end
    endtask

    task automatic test_sw_set();
        do_reset(4'b0000);
        bus_write(4'b0011, 4'b1111);
        tick();
        n_checks++;
        if (value[4] !== 4'b1011) begin
            n_fail++; $display("FAIL sw_set value=%b required 1011", value[4]);
        end
        bus_write(4'b0100, 4'b1111); hw_event = 4'b0100;
        tick();
        n_checks++;
        if (value[4] !== 4'b1111) begin
            n_fail++; $display("FAIL sw_set_wins value=%b required 1111", value[4]);
        end
        bus_idle(); hw_event = 4'b0001;
        tick();
        hw_event = '0;
        n_checks++;
        if (value[4] !== 4'b1110 || ovf[4] !== 4'b0000) begin
            n_fail++; $display("FAIL hw_clear value=%b ovf=%b required 1110/0000", value[4], ovf[4]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (value[4] !== 4'b1000 || value[0] !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset E=%b A=%b required 1000/0000", value[4], value[0]);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset(4'b0000);
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(99) == 0);
            hw_event = 4'($urandom & $urandom);
            cv       = ($urandom_range(3) != 0);
            sel      = ($urandom_range(3) != 0);
            wr       = $urandom_range(1) == 1;
            wdata    = 4'($urandom);
            wmask    = 4'($urandom);
            if ($urandom_range(7) == 0) irq_en = 4'($urandom);
            tick();
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (value[k] !== m_val[k] || ovf[k] !== m_ovf[k] || irq[k] !== m_irq[k]) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc=%0d value=%b ovf=%b irq=%b required %b/%b/%b",
                             k, i, value[k], ovf[k], irq[k], m_val[k], m_ovf[k], m_irq[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_level_set();
        test_write_clear();
        test_simultaneous();
        test_edge();
        test_read_clear();
        test_sw_set();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
